// File: rtl/memory_arbiter.sv
// Arbitrates the single-ported main memory between instruction fetch (read-only)
// and the data port; data wins contention, bounded by a starvation streak counter.
module memory_arbiter #(
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     fetch_request,
  input  logic [ADDRESS_WIDTH-1:0] fetch_address,
  output logic                     fetch_ready,
  output logic                     fetch_response_valid,
  output logic [DATA_WIDTH-1:0]    fetch_read_data,
  input  logic                     data_request,
  input  logic                     data_write,
  input  logic [ADDRESS_WIDTH-1:0] data_address,
  input  logic [DATA_WIDTH-1:0]    data_write_value,
  output logic                     data_ready,
  output logic                     data_response_valid,
  output logic [DATA_WIDTH-1:0]    data_read_data,
  output logic                     data_error,
  output logic                     mem_read_enable,
  output logic [ADDRESS_WIDTH-1:0] mem_read_address,
  input  logic [DATA_WIDTH-1:0]    mem_read_value,
  output logic                     mem_write_enable,
  output logic [ADDRESS_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0]    mem_write_value
);

  localparam logic [3:0]               STREAK_MAX = 4'(MAX_DATA_STREAK);
  localparam logic [ADDRESS_WIDTH-1:0] WORD_MASK  = ~ADDRESS_WIDTH'(3);

  // Owner and kind of the single outstanding response, folded into one state.
  typedef enum logic [2:0] {
    RSP_NONE,
    RSP_FETCH_READ,
    RSP_DATA_READ,
    RSP_DATA_WRITE,
    RSP_DATA_ERROR
  } rsp_e;

  rsp_e       rsp_q, rsp_d;
  logic [3:0] streak_q, streak_d;
  logic       fetch_grant;
  logic       data_grant;
  logic       data_misaligned;

  assign data_misaligned = (data_address[1:0] != 2'b00);

  // Grants are qualified by reset_n so nothing reaches memory while in reset.
  always_comb begin
    data_grant  = reset_n && data_request &&
                  !(fetch_request && (streak_q == STREAK_MAX));
    fetch_grant = reset_n && fetch_request && !data_grant;
  end

  assign fetch_ready = fetch_grant;
  assign data_ready  = data_grant;

  always_comb begin
    streak_d = streak_q;
    if (!fetch_request || fetch_grant) begin
      streak_d = '0;
    end else if (data_grant && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  always_comb begin
    rsp_d = RSP_NONE;
    if (fetch_grant) begin
      rsp_d = RSP_FETCH_READ;
    end else if (data_grant) begin
      if (data_misaligned) rsp_d = RSP_DATA_ERROR;
      else if (data_write) rsp_d = RSP_DATA_WRITE;
      else                 rsp_d = RSP_DATA_READ;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_q    <= RSP_NONE;
      streak_q <= '0;
    end else begin
      rsp_q    <= rsp_d;
      streak_q <= streak_d;
    end
  end

  // Stores mirror the address onto read_address: the memory indexes writes by it.
  always_comb begin
    mem_read_enable   = 1'b0;
    mem_read_address  = '0;
    mem_write_enable  = 1'b0;
    mem_write_address = '0;
    mem_write_value   = '0;
    if (fetch_grant) begin
      mem_read_enable  = 1'b1;
      mem_read_address = fetch_address & WORD_MASK;
    end else if (data_grant && !data_misaligned) begin
      mem_read_address = data_address;
      if (data_write) begin
        mem_write_enable  = 1'b1;
        mem_write_address = data_address;
        mem_write_value   = data_write_value;
      end else begin
        mem_read_enable = 1'b1;
      end
    end
  end

  always_comb begin
    fetch_response_valid = (rsp_q == RSP_FETCH_READ);
    data_response_valid  = (rsp_q == RSP_DATA_READ) || (rsp_q == RSP_DATA_WRITE) ||
                           (rsp_q == RSP_DATA_ERROR);
    data_error           = (rsp_q == RSP_DATA_ERROR);
    fetch_read_data      = (rsp_q == RSP_FETCH_READ) ? mem_read_value : '0;
    data_read_data       = (rsp_q == RSP_DATA_READ)  ? mem_read_value : '0;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: cycle-by-cycle vector table plus reset sequences,
// with a 1 KB registered-read memory model whose idle output is a junk pattern.
module tb_memory_arbiter;

  logic        clock;
  logic        reset_n;
  logic        fetch_request;
  logic [31:0] fetch_address;
  logic        fetch_ready;
  logic        fetch_response_valid;
  logic [31:0] fetch_read_data;
  logic        data_request;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_write_value;
  logic        data_ready;
  logic        data_response_valid;
  logic [31:0] data_read_data;
  logic        data_error;
  logic        mem_read_enable;
  logic [31:0] mem_read_address;
  logic [31:0] mem_read_value;
  logic        mem_write_enable;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_value;

  memory_arbiter #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH(32),
    .MAX_DATA_STREAK(4)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .fetch_request(fetch_request),
    .fetch_address(fetch_address),
    .fetch_ready(fetch_ready),
    .fetch_response_valid(fetch_response_valid),
    .fetch_read_data(fetch_read_data),
    .data_request(data_request),
    .data_write(data_write),
    .data_address(data_address),
    .data_write_value(data_write_value),
    .data_ready(data_ready),
    .data_response_valid(data_response_valid),
    .data_read_data(data_read_data),
    .data_error(data_error),
    .mem_read_enable(mem_read_enable),
    .mem_read_address(mem_read_address),
    .mem_read_value(mem_read_value),
    .mem_write_enable(mem_write_enable),
    .mem_write_address(mem_write_address),
    .mem_write_value(mem_write_value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: word i holds C0DE0000|i; outside read-response cycles the
  // output carries a junk pattern standing in for a floating bus.
  logic [31:0] mem [256];
  logic [31:0] rdata_q;
  logic        rd_valid_q;
  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
      rd_valid_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rd_valid_q <= mem_read_enable;
      if (mem_read_enable)  rdata_q <= mem[mem_read_address[9:2]];
      if (mem_write_enable) mem[mem_read_address[9:2]] <= mem_write_value;
    end
  end
  assign mem_read_value = rd_valid_q ? rdata_q : 32'hBAD0_BAD0;

  typedef struct {
    logic        fr;  logic [31:0] fa;
    logic        dr;  logic dw; logic [31:0] da; logic [31:0] dv;
    logic        e_frdy; logic e_drdy;
    logic        e_re;   logic [31:0] e_ra;
    logic        e_we;   logic [31:0] e_wa; logic [31:0] e_wv;
    logic        e_frv;  logic [31:0] e_frd;
    logic        e_drv;  logic [31:0] e_drd; logic e_derr;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [31:0] W0 = 32'hC0DE_0000, W1 = 32'hC0DE_0001, W2 = 32'hC0DE_0002;
  localparam logic [31:0] W3 = 32'hC0DE_0003, W4 = 32'hC0DE_0004, W8 = 32'hC0DE_0008;
  localparam logic [31:0] BEEF = 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic fr, input logic [31:0] fa, input logic dr, input logic dw,
                     input logic [31:0] da, input logic [31:0] dv,
                     input logic frdy, input logic drdy, input logic re, input logic [31:0] ra,
                     input logic we, input logic [31:0] wa, input logic [31:0] wv,
                     input logic frv, input logic [31:0] frd,
                     input logic drv, input logic [31:0] drd, input logic derr);
    vec_t v;
    v.fr = fr; v.fa = fa; v.dr = dr; v.dw = dw; v.da = da; v.dv = dv;
    v.e_frdy = frdy; v.e_drdy = drdy; v.e_re = re; v.e_ra = ra;
    v.e_we = we; v.e_wa = wa; v.e_wv = wv;
    v.e_frv = frv; v.e_frd = frd; v.e_drv = drv; v.e_drd = drd; v.e_derr = derr;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic fr, input logic [31:0] fa, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dv);
    fetch_request = fr; fetch_address = fa;
    data_request = dr; data_write = dw; data_address = da; data_write_value = dv;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " fetch_ready"}, 32'(fetch_ready), 32'd0);
    chk({tag, " data_ready"}, 32'(data_ready), 32'd0);
    chk({tag, " mem_read_enable"}, 32'(mem_read_enable), 32'd0);
    chk({tag, " mem_write_enable"}, 32'(mem_write_enable), 32'd0);
    chk({tag, " fetch_response_valid"}, 32'(fetch_response_valid), 32'd0);
    chk({tag, " data_response_valid"}, 32'(data_response_valid), 32'd0);
    chk({tag, " data_error"}, 32'(data_error), 32'd0);
    chk({tag, " fetch_read_data"}, fetch_read_data, 32'd0);
    chk({tag, " data_read_data"}, data_read_data, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string    p;
    logic     exp_d [5];
    // Inputs: fr fa dr dw da dv | grants/mem: frdy drdy re ra we wa wv | responses: frv frd drv drd derr
    add(0, 0,     0, 0, 0,     0,    0, 0, 0, 0,     0, 0,     0,    0, 0,  0, 0,    0);
    add(1, 32'h0, 0, 0, 0,     0,    1, 0, 1, 32'h0, 0, 0,     0,    0, 0,  0, 0,    0);
    add(1, 32'h4, 0, 0, 0,     0,    1, 0, 1, 32'h4, 0, 0,     0,    1, W0, 0, 0,    0);
    add(1, 32'h8, 0, 0, 0,     0,    1, 0, 1, 32'h8, 0, 0,     0,    1, W1, 0, 0,    0);
    add(0, 0,     0, 0, 0,     0,    0, 0, 0, 0,     0, 0,     0,    1, W2, 0, 0,    0);
    add(0, 0,     1, 1, 32'h40, BEEF, 0, 1, 0, 32'h40, 1, 32'h40, BEEF, 0, 0,  0, 0,    0);
    add(0, 0,     1, 0, 32'h40, 0,   0, 1, 1, 32'h40, 0, 0,     0,    0, 0,  1, 0,    0);
    add(0, 0,     0, 0, 0,     0,    0, 0, 0, 0,     0, 0,     0,    0, 0,  1, BEEF, 0);
    add(0, 0,     1, 0, 32'h42, 0,   0, 1, 0, 0,     0, 0,     0,    0, 0,  0, 0,    0);
    add(0, 0,     0, 0, 0,     0,    0, 0, 0, 0,     0, 0,     0,    0, 0,  1, 0,    1);
    // Contention: fetch at 0x13 (low bits ignored -> word 4), data load at 0x20 (word 8)
    add(1, 32'h13, 1, 0, 32'h20, 0,  0, 1, 1, 32'h20, 0, 0,     0,    0, 0,  0, 0,    0);
    add(1, 32'h13, 1, 0, 32'h20, 0,  0, 1, 1, 32'h20, 0, 0,     0,    0, 0,  1, W8,   0);
    add(1, 32'h13, 1, 0, 32'h20, 0,  0, 1, 1, 32'h20, 0, 0,     0,    0, 0,  1, W8,   0);
    add(1, 32'h13, 1, 0, 32'h20, 0,  0, 1, 1, 32'h20, 0, 0,     0,    0, 0,  1, W8,   0);
    add(1, 32'h13, 1, 0, 32'h20, 0,  1, 0, 1, 32'h10, 0, 0,     0,    0, 0,  1, W8,   0);
    add(1, 32'h13, 1, 0, 32'h20, 0,  0, 1, 1, 32'h20, 0, 0,     0,    1, W4, 0, 0,    0);
    add(1, 32'h13, 1, 0, 32'h20, 0,  0, 1, 1, 32'h20, 0, 0,     0,    0, 0,  1, W8,   0);
    add(1, 32'h13, 1, 0, 32'h20, 0,  0, 1, 1, 32'h20, 0, 0,     0,    0, 0,  1, W8,   0);
    // Fetch drops for one cycle: streak (3 here) must clear, so four more data grants follow
    add(0, 0,      1, 0, 32'h20, 0,  0, 1, 1, 32'h20, 0, 0,     0,    0, 0,  1, W8,   0);
    add(1, 32'h13, 1, 0, 32'h20, 0,  0, 1, 1, 32'h20, 0, 0,     0,    0, 0,  1, W8,   0);
    add(1, 32'h13, 1, 0, 32'h20, 0,  0, 1, 1, 32'h20, 0, 0,     0,    0, 0,  1, W8,   0);
    add(1, 32'h13, 1, 0, 32'h20, 0,  0, 1, 1, 32'h20, 0, 0,     0,    0, 0,  1, W8,   0);
    add(1, 32'h13, 1, 0, 32'h20, 0,  0, 1, 1, 32'h20, 0, 0,     0,    0, 0,  1, W8,   0);
    add(1, 32'h13, 1, 0, 32'h20, 0,  1, 0, 1, 32'h10, 0, 0,     0,    0, 0,  1, W8,   0);
    add(0, 0,      0, 0, 0,      0,  0, 0, 0, 0,      0, 0,     0,    1, W4, 0, 0,    0);
    add(0, 0,      0, 0, 0,      0,  0, 0, 0, 0,      0, 0,     0,    0, 0,  0, 0,    0);

    // Reset with requests held high: everything quiet
    reset_n = 1'b0;
    drive(1, 32'h4, 1, 0, 32'h20, 0);
    #1;
    chk_quiet("reset");
    repeat (2) @(negedge clock);
    chk_quiet("reset_hold");
    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].fr, vecs[i].fa, vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dv);
      #1;
      p = $sformatf("row%0d", i);
      chk({p, " fetch_ready"}, 32'(fetch_ready), 32'(vecs[i].e_frdy));
      chk({p, " data_ready"}, 32'(data_ready), 32'(vecs[i].e_drdy));
      chk({p, " mem_read_enable"}, 32'(mem_read_enable), 32'(vecs[i].e_re));
      chk({p, " mem_read_address"}, mem_read_address, vecs[i].e_ra);
      chk({p, " mem_write_enable"}, 32'(mem_write_enable), 32'(vecs[i].e_we));
      chk({p, " mem_write_address"}, mem_write_address, vecs[i].e_wa);
      chk({p, " mem_write_value"}, mem_write_value, vecs[i].e_wv);
      chk({p, " fetch_response_valid"}, 32'(fetch_response_valid), 32'(vecs[i].e_frv));
      chk({p, " fetch_read_data"}, fetch_read_data, vecs[i].e_frd);
      chk({p, " data_response_valid"}, 32'(data_response_valid), 32'(vecs[i].e_drv));
      chk({p, " data_read_data"}, data_read_data, vecs[i].e_drd);
      chk({p, " data_error"}, 32'(data_error), 32'(vecs[i].e_derr));
    end

    // Reset one cycle after a fetch grant: the in-flight response is dropped
    @(negedge clock);
    drive(1, 32'h8, 0, 0, 0, 0);
    #1;
    chk("midrd grant fetch_ready", 32'(fetch_ready), 32'd1);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("midrd fetch_response_valid", 32'(fetch_response_valid), 32'd0);
    chk("midrd fetch_read_data", fetch_read_data, 32'd0);
    @(negedge clock);
    chk_quiet("midrd_hold");
    reset_n = 1'b1;
    #1;
    chk("midrd release fetch_response_valid", 32'(fetch_response_valid), 32'd0);
    @(negedge clock);
    #1;
    chk("midrd after fetch_response_valid", 32'(fetch_response_valid), 32'd0);
    drive(1, 32'hC, 0, 0, 0, 0);
    #1;
    chk("midrd new fetch_ready", 32'(fetch_ready), 32'd1);
    chk("midrd new mem_read_address", mem_read_address, 32'hC);
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("midrd new fetch_response_valid", 32'(fetch_response_valid), 32'd1);
    chk("midrd new fetch_read_data", fetch_read_data, W3);

    // Build a streak of 3, reset, then DDDDF must follow from zero
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      drive(1, 32'h0, 1, 0, 32'h20, 0);
      #1;
      chk($sformatf("streak pre%0d data_ready", c), 32'(data_ready), 32'd1);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk_quiet("streak_reset");
    @(negedge clock);
    reset_n = 1'b1;
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clock);
      #1;
      chk($sformatf("streak post%0d data_ready", c), 32'(data_ready), 32'(exp_d[c]));
      chk($sformatf("streak post%0d fetch_ready", c), 32'(fetch_ready), 32'(!exp_d[c]));
    end
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
